mcs4_cycle_ctrl: RTL and testbench
==================================

// Module: mcs4_cycle_ctrl
// PURPOSE
//  Master timing controller for the MCS-4 system (i4004 CPU, i4001 ROM, i4002 RAM on the shared 4-bit bus).
//  - Generates the two-phase clock enables clken_1/clken_2 that all chips share.
//  - Tracks the 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from the CPU's sync output.
//  - Gives the host run / halt / single-step control at instruction boundaries, plus an instruction counter.
// PARAMETERS
//  DIV        4   system clk ticks per 4004 clock period; even, >= 4
//  RESET_RUN  1   1: enter RUN after reset; 0: enter HALTED
//  CNT_W      16  width of instr_count
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  run_req      in   1      pulse: free-run
//  halt_req     in   1      pulse: stop at next instruction boundary
//  step_req     in   1      pulse: execute exactly one instruction (from HALTED)
//  sync         in   1      i4004 sync; marks X3 (next period is A1)
//  clken_1      out  1      phase-1 enable, one clk wide
//  clken_2      out  1      phase-2 enable, one clk wide
//  subcycle     out  3      current subcycle, 0=A1 .. 7=X3
//  locked       out  1      subcycle is aligned to sync
//  halted       out  1      state==HALTED
//  step_done    out  1      pulse: single step completed
//  sync_err     out  1      pulse: sync missing or in an unexpected place
//  instr_count  out  CNT_W  count of completed instructions (while locked)
// BEHAVIOUR
//  Reset values: clken_1=clken_2=0, subcycle=0, locked=0, step_done=0, sync_err=0, instr_count=0,
//   tick counter cnt=0, pending-halt flag=0. State: RUN if RESET_RUN=1, else HALTED (halted=1).
//  Reset mid-operation: reset wins over all other inputs and restores the reset values in the same cycle.
//  Tick counter: cnt counts 0..DIV-1 and wraps, but only in RUN or STEP. In HALTED it is held at 0.
//  Enables are registered and asserted only in RUN or STEP:
//   clken_1=1 in the cycle when cnt==0; clken_2=1 in the cycle when cnt==DIV/2.
//  Period end (PE) is the cycle where cnt==DIV-1. sync is sampled only at PE.
//  At PE:
//   - sync=1, !locked: subcycle<=0 and locked<=1. No error; instr_count unchanged.
//   - sync=1, locked, subcycle==7: subcycle<=0 and instr_count+=1 (wraps mod 2^CNT_W).
//     This is an instruction boundary (IB).
//   - sync=1, locked, subcycle!=7: sync_err pulses one cycle; subcycle<=0; locked stays 1; no count.
//   - sync=0, locked, subcycle==7: sync_err pulses; locked<=0; subcycle<=0.
//   - sync=0 otherwise: subcycle<=subcycle+1 (mod 8).
//  Boundary: an IB is any PE with sync=1 (this includes the lock-acquire case).
//  State machine (states HALTED, RUN, STEP):
//   - HALTED + run_req: RUN. Next cycle cnt=0 and clken_1=1 (one-cycle latency).
//   - HALTED + step_req (no run_req): STEP, with the same start latency.
//   - HALTED + run_req and step_req together: run_req wins.
//   - RUN + halt_req: pending_halt<=1. At the next boundary PE, go to HALTED and clear pending_halt.
//   - RUN + halt_req while !locked: also waits for a boundary. Halt is never taken mid-instruction.
//   - RUN + run_req clears pending_halt. If run_req and halt_req arrive together, halt wins.
//   - RUN: step_req is ignored.
//   - STEP: at the next boundary PE, go to HALTED and pulse step_done in the cycle halted rises.
//   - STEP: halt_req is ignored. run_req converts to RUN and no step_done is issued.
//   - HALTED: halt_req is ignored.
//  In HALTED, subcycle, locked and instr_count hold their values. After a halt, subcycle==0 (A1 next).
// TESTING
//  T1  DIV=4, RESET_RUN=1, release rst at cycle 0.
//      -> clken_1 in cycles 1,5,9,...; clken_2 in cycles 3,7,11,...; never both high.
//  T2  CPU model drives sync at every 8th PE; first sync at PE #3.
//      -> locked=1 after PE #3; subcycle then runs 0..7; instr_count=5 after 5 further boundaries.
//  T3  halt_req while subcycle=2, locked.
//      -> clken pulses continue through X3; halted=1 the cycle after the IB PE; subcycle=0; no clken afterwards.
//  T4  From HALTED, step_req.
//      -> exactly 8 clken_1 pulses; step_done pulses once; halted=1; instr_count+=1.
//  T5  Inject sync at subcycle 4, then drop sync at X3.
//      -> sync_err pulses each time; subcycle resets to 0; locked=0 after the drop.
//  T6  Assert rst during STEP at subcycle 5.
//      -> all outputs at reset values next cycle; RUN resumes (RESET_RUN=1); instr_count=0.

Source files
------------

// File: rtl/mcs4_cycle_ctrl.sv
// mcs4_cycle_ctrl: master timing controller for an MCS-4 system.
// Generates the shared two-phase clock enables and tracks the 8-subcycle
// instruction cycle from the CPU's sync output. It also provides run, halt
// and single-step control at instruction boundaries, plus an instruction counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HALTED | tick counter held at 0, no clock enables, cycle state frozen
// RUN    | free-running; a pending halt is taken at the next boundary
// STEP   | running one instruction; stops at the next boundary
module mcs4_cycle_ctrl #(
  parameter int DIV       = 4,
  parameter bit RESET_RUN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             sync,
  output logic             clken_1,
  output logic             clken_2,
  output logic [2:0]       subcycle,
  output logic             locked,
  output logic             halted,
  output logic             step_done,
  output logic             sync_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clken_1_q, clken_1_d;
  logic             clken_2_q, clken_2_d;
  logic [2:0]       subcycle_q, subcycle_d;
  logic             locked_q, locked_d;
  logic             step_done_q, step_done_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             pending_q, pending_d;

  logic running_q, running_d, pe, ib, halt_eff;

  // Next-state logic: run control FSM, tick counter, enables and subcycle tracking
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    subcycle_d    = subcycle_q;
    locked_d      = locked_q;
    instr_count_d = instr_count_q;
    pending_d     = pending_q;
    step_done_d   = 1'b0;
    sync_err_d    = 1'b0;
    halt_eff      = 1'b0;

    running_q = (state_q != S_HALTED);
    pe        = running_q && (cnt_q == CNT_LAST);
    ib        = pe && sync;

    case (state_q)
      S_HALTED: begin
        pending_d = 1'b0;
        if (run_req)       state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_RUN: begin
        // A simultaneous halt_req beats run_req; run_req alone cancels a pending halt.
        halt_eff  = halt_req || (pending_q && !run_req);
        pending_d = halt_eff;
        if (ib && halt_eff) begin
          state_d   = S_HALTED;
          pending_d = 1'b0;
        end
      end
      S_STEP: begin
        if (run_req) begin
          state_d = S_RUN;
        end else if (ib) begin
          state_d     = S_HALTED;
          step_done_d = 1'b1;
        end
      end
      default: state_d = S_HALTED;
    endcase

    running_d = (state_d != S_HALTED);

    // The counter leaves 0 only after the clken_1 for that slot has been issued,
    // so a fresh start (after reset or from HALTED) begins with a full period.
    if (!running_q)                      cnt_d = '0;
    else if (cnt_q == '0 && !clken_1_q)  cnt_d = '0;
    else if (cnt_q == CNT_LAST)          cnt_d = '0;
    else                                 cnt_d = cnt_q + CW'(1);

    clken_1_d = running_d && (cnt_d == '0);
    clken_2_d = running_d && (cnt_d == CNT_HALF);

    if (pe) begin
      if (sync) begin
        subcycle_d = 3'd0;
        if (!locked_q) begin
          locked_d = 1'b1;
        end else if (subcycle_q == 3'd7) begin
          instr_count_d = instr_count_q + CNT_W'(1);
        end else begin
          sync_err_d = 1'b1;
        end
      end else if (locked_q && subcycle_q == 3'd7) begin
        sync_err_d = 1'b1;
        locked_d   = 1'b0;
        subcycle_d = 3'd0;
      end else begin
        subcycle_d = subcycle_q + 3'd1;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RESET_RUN ? S_RUN : S_HALTED;
      cnt_q         <= '0;
      clken_1_q     <= 1'b0;
      clken_2_q     <= 1'b0;
      subcycle_q    <= 3'd0;
      locked_q      <= 1'b0;
      step_done_q   <= 1'b0;
      sync_err_q    <= 1'b0;
      instr_count_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clken_1_q     <= clken_1_d;
      clken_2_q     <= clken_2_d;
      subcycle_q    <= subcycle_d;
      locked_q      <= locked_d;
      step_done_q   <= step_done_d;
      sync_err_q    <= sync_err_d;
      instr_count_q <= instr_count_d;
      pending_q     <= pending_d;
    end
  end

  assign clken_1     = clken_1_q;
  assign clken_2     = clken_2_q;
  assign subcycle    = subcycle_q;
  assign locked      = locked_q;
  assign halted      = (state_q == S_HALTED);
  assign step_done   = step_done_q;
  assign sync_err    = sync_err_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mcs4_cycle_ctrl.sv
// Testbench for mcs4_cycle_ctrl (DIV=4, RESET_RUN=1). Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_mcs4_cycle_ctrl;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, sync = 1'b0;
  logic clken_1, clken_2, locked, halted, step_done, sync_err;
  logic [2:0] subcycle;
  logic [CNT_W-1:0] instr_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_c1 = 0, n_c2 = 0, n_both = 0, n_err = 0, n_done = 0, n_done_bad = 0;
  int q1[$];
  int q2[$];
  int exp_cnt_q[$];

  mcs4_cycle_ctrl #(.DIV(4), .RESET_RUN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .sync(sync), .clken_1(clken_1), .clken_2(clken_2), .subcycle(subcycle),
    .locked(locked), .halted(halted), .step_done(step_done), .sync_err(sync_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // one clock, then tally the pulse outputs seen in the new cycle
  task automatic step1();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (clken_1) n_c1++;
    if (clken_2) n_c2++;
    if (clken_1 && clken_2) n_both++;
    if (sync_err) n_err++;
    if (step_done) begin
      n_done++;
      if (!halted) n_done_bad++;
    end
  endtask

  // one 4004 clock period, starting from the cycle where clken_1 is high;
  // request inputs are pulsed in the first cycle, sync is held through the period end
  task automatic run_period(input logic s, input logic r, input logic h, input logic st);
    sync = s; run_req = r; halt_req = h; step_req = st;
    step1();
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    repeat (3) step1();
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step1();
    vectors++; if (clken_1 !== 1'b0) begin miscompares++; $display("FAIL reset_clken_1: got %b expected 0", clken_1); end
    vectors++; if (clken_2 !== 1'b0) begin miscompares++; $display("FAIL reset_clken_2: got %b expected 0", clken_2); end
    vectors++; if (subcycle !== 3'd0) begin miscompares++; $display("FAIL reset_subcycle: got %0d expected 0", subcycle); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", locked); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", halted); end
    vectors++; if (step_done !== 1'b0 || sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", step_done, sync_err); end
    vectors++; if (instr_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
  endtask

  task automatic test_clken();
    int e;
    q1 = {1, 5, 9, 13};
    q2 = {3, 7, 11, 15};
    n_both = 0;
    rst = 1'b0;
    cyc = 0;
    repeat (16) begin
      step1();
      if (clken_1) begin
        e = (q1.size() > 0) ? q1.pop_front() : -1;
        vectors++; if (e != cyc) begin miscompares++; $display("FAIL clken_1_cycle: got cycle %0d expected %0d", cyc, e); end
      end
      if (clken_2) begin
        e = (q2.size() > 0) ? q2.pop_front() : -1;
        vectors++; if (e != cyc) begin miscompares++; $display("FAIL clken_2_cycle: got cycle %0d expected %0d", cyc, e); end
      end
    end
    vectors++; if (q1.size() != 0 || q2.size() != 0) begin miscompares++; $display("FAIL clken_missing: got %0d/%0d unseen expected 0/0", q1.size(), q2.size()); end
    vectors++; if (n_both != 0) begin miscompares++; $display("FAIL clken_overlap: got %0d expected 0", n_both); end
    step1();
    vectors++; if (clken_1 !== 1'b1) begin miscompares++; $display("FAIL clken_1_cycle17: got %b expected 1", clken_1); end
  endtask

  task automatic test_lock_count();
    int e;
    n_err = 0;
    run_period(1'b0, 1'b0, 1'b0, 1'b0);
    run_period(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL prelock: got %b expected 0", locked); end
    run_period(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++; if (locked !== 1'b1 || subcycle !== 3'd0) begin miscompares++; $display("FAIL lock_acquire: got locked=%b sc=%0d expected 1 0", locked, subcycle); end
    vectors++; if (instr_count !== '0 || n_err != 0) begin miscompares++; $display("FAIL lock_no_count: got cnt=%0d err=%0d expected 0 0", instr_count, n_err); end
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 8; k++) begin
        vectors++; if (subcycle !== 3'(k)) begin miscompares++; $display("FAIL subcycle_seq: got %0d expected %0d", subcycle, k); end
        if (k == 7) exp_cnt_q.push_back(i + 1);
        run_period(k == 7, 1'b0, 1'b0, 1'b0);
      end
      e = exp_cnt_q.pop_front();
      vectors++; if (instr_count !== CNT_W'(e)) begin miscompares++; $display("FAIL instr_count: got %0d expected %0d", instr_count, e); end
    end
    vectors++; if (n_err != 0) begin miscompares++; $display("FAIL spurious_sync_err: got %0d expected 0", n_err); end
  endtask

  task automatic test_halt();
    int e;
    run_period(1'b0, 1'b0, 1'b0, 1'b0);
    run_period(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (subcycle !== 3'd2) begin miscompares++; $display("FAIL halt_setup_sc: got %0d expected 2", subcycle); end
    n_c1 = 0;
    run_period(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 3; k < 7; k++) run_period(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early: got %b expected 0", halted); end
    exp_cnt_q.push_back(6);
    run_period(1'b1, 1'b0, 1'b0, 1'b0);
    e = exp_cnt_q.pop_front();
    vectors++; if (halted !== 1'b1 || subcycle !== 3'd0) begin miscompares++; $display("FAIL halt_at_ib: got halted=%b sc=%0d expected 1 0", halted, subcycle); end
    vectors++; if (instr_count !== CNT_W'(e)) begin miscompares++; $display("FAIL halt_count: got %0d expected %0d", instr_count, e); end
    vectors++; if (n_c1 != 5) begin miscompares++; $display("FAIL halt_clken_through_x3: got %0d expected 5", n_c1); end
    n_c1 = 0; n_c2 = 0;
    repeat (8) step1();
    vectors++; if (n_c1 + n_c2 != 0 || halted !== 1'b1) begin miscompares++; $display("FAIL halted_quiet: got pulses=%0d halted=%b expected 0 1", n_c1 + n_c2, halted); end
  endtask

  task automatic test_step();
    n_c1 = 0; n_done = 0; n_done_bad = 0;
    step_req = 1'b1;
    step1();
    step_req = 1'b0;
    for (int k = 0; k < 8; k++) run_period(k == 7, 1'b0, 1'b0, 1'b0);
    vectors++; if (step_done !== 1'b1 || halted !== 1'b1) begin miscompares++; $display("FAIL step_done_edge: got done=%b halted=%b expected 1 1", step_done, halted); end
    repeat (4) step1();
    vectors++; if (n_c1 != 8) begin miscompares++; $display("FAIL step_clken_1: got %0d expected 8", n_c1); end
    vectors++; if (n_done != 1 || n_done_bad != 0) begin miscompares++; $display("FAIL step_done_count: got %0d (bad %0d) expected 1 (0)", n_done, n_done_bad); end
    vectors++; if (instr_count !== CNT_W'(7) || subcycle !== 3'd0) begin miscompares++; $display("FAIL step_count: got cnt=%0d sc=%0d expected 7 0", instr_count, subcycle); end
  endtask

  task automatic test_sync_err();
    n_err = 0;
    run_req = 1'b1;
    step1();
    run_req = 1'b0;
    vectors++; if (clken_1 !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL run_start: got clken_1=%b halted=%b expected 1 0", clken_1, halted); end
    for (int k = 0; k < 4; k++) run_period(1'b0, 1'b0, 1'b0, 1'b0);
    run_period(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++; if (n_err != 1 || subcycle !== 3'd0 || locked !== 1'b1) begin miscompares++; $display("FAIL early_sync: got err=%0d sc=%0d locked=%b expected 1 0 1", n_err, subcycle, locked); end
    for (int k = 0; k < 8; k++) run_period(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (n_err != 2 || subcycle !== 3'd0 || locked !== 1'b0) begin miscompares++; $display("FAIL missing_sync: got err=%0d sc=%0d locked=%b expected 2 0 0", n_err, subcycle, locked); end
    run_period(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++; if (locked !== 1'b1 || n_err != 2 || instr_count !== CNT_W'(7)) begin miscompares++; $display("FAIL relock: got locked=%b err=%0d cnt=%0d expected 1 2 7", locked, n_err, instr_count); end
  endtask

  task automatic test_reset_mid();
    run_period(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) run_period(k == 7, 1'b0, 1'b0, 1'b0);
    vectors++; if (halted !== 1'b1 || instr_count !== CNT_W'(8)) begin miscompares++; $display("FAIL pre_reset_halt: got halted=%b cnt=%0d expected 1 8", halted, instr_count); end
    step_req = 1'b1;
    step1();
    step_req = 1'b0;
    for (int k = 0; k < 5; k++) run_period(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (subcycle !== 3'd5 || halted !== 1'b0) begin miscompares++; $display("FAIL step_mid: got sc=%0d halted=%b expected 5 0", subcycle, halted); end
    rst = 1'b1;
    step1();
    vectors++; if ({clken_1, clken_2, locked, halted, step_done, sync_err} !== 6'b0) begin miscompares++; $display("FAIL mid_reset_flags: got %b expected 000000", {clken_1, clken_2, locked, halted, step_done, sync_err}); end
    vectors++; if (subcycle !== 3'd0 || instr_count !== '0) begin miscompares++; $display("FAIL mid_reset_vals: got sc=%0d cnt=%0d expected 0 0", subcycle, instr_count); end
    rst = 1'b0;
    step1();
    vectors++; if (clken_1 !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL resume_run: got clken_1=%b halted=%b expected 1 0", clken_1, halted); end
  endtask

  task automatic test_back_to_back();
    run_period(1'b0, 1'b1, 1'b1, 1'b0);
    run_period(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_mid_instr: got %b expected 0", halted); end
    run_period(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++; if (halted !== 1'b1 || locked !== 1'b1 || instr_count !== '0) begin miscompares++; $display("FAIL halt_wins: got halted=%b locked=%b cnt=%0d expected 1 1 0", halted, locked, instr_count); end
    n_done = 0;
    run_req = 1'b1; step_req = 1'b1;
    step1();
    run_req = 1'b0; step_req = 1'b0;
    for (int k = 0; k < 8; k++) run_period(k == 7, 1'b0, 1'b0, 1'b0);
    vectors++; if (halted !== 1'b0 || n_done != 0 || instr_count !== CNT_W'(1)) begin miscompares++; $display("FAIL run_beats_step: got halted=%b done=%0d cnt=%0d expected 0 0 1", halted, n_done, instr_count); end
    run_period(1'b0, 1'b0, 1'b1, 1'b0);
    run_period(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k < 8; k++) run_period(k == 7, 1'b0, 1'b0, 1'b0);
    vectors++; if (halted !== 1'b0 || instr_count !== CNT_W'(2)) begin miscompares++; $display("FAIL run_cancels_halt: got halted=%b cnt=%0d expected 0 2", halted, instr_count); end
  endtask

  initial begin
    test_reset();
    test_clken();
    test_lock_count();
    test_halt();
    test_step();
    test_sync_err();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
